// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared 32-bit ALU: it arbitrates, registers the operands,
// captures the ALU result one cycle later and returns it on a tagged response channel.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid0,
  input  logic        ReqValid1,
  output logic        ReqReady0,
  output logic        ReqReady1,
  input  logic [3:0]  ReqOp0,
  input  logic [3:0]  ReqOp1,
  input  logic [31:0] ReqA0,
  input  logic [31:0] ReqA1,
  input  logic [31:0] ReqB0,
  input  logic [31:0] ReqB1,
  input  logic [4:0]  ReqShamt0,
  input  logic [4:0]  ReqShamt1,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspData,
  output logic        RspZero,
  output logic        RspId,
  output logic [3:0]  ALUOp,
  output logic [4:0]  shamt,
  output logic [31:0] DataIn1,
  output logic [31:0] regData2,
  output logic        ALUSrc,
  output logic        jump,
  input  logic [31:0] DataOut,
  input  logic        Zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        last_grant_r;
  logic        grant_id_r;
  logic        window_s;
  logic        grant_sel_s;
  logic        accept_s;
  logic [3:0]  op_r;
  logic [4:0]  shamt_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] rsp_data_r;
  logic        rsp_zero_r;
  logic        rsp_id_r;

  // Accept window and grant selection; nothing is accepted while reset is held.
  always_comb begin
    case (state_r)
      IDLE:    window_s = 1'b1;
      RESP:    window_s = RspReady;
      default: window_s = 1'b0;
    endcase
    if (ReqValid0 && !ReqValid1) begin
      grant_sel_s = 1'b0;
    end else if (ReqValid1 && !ReqValid0) begin
      grant_sel_s = 1'b1;
    end else if (RR_EN) begin
      grant_sel_s = ~last_grant_r;
    end else begin
      grant_sel_s = 1'b0;
    end
    accept_s = window_s && (ReqValid0 || ReqValid1) && !reset;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = EXEC;
        else          state_nxt_s = IDLE;
      end
      EXEC:    state_nxt_s = RESP;
      RESP: begin
        if (!RspReady)     state_nxt_s = RESP;
        else if (accept_s) state_nxt_s = EXEC;
        else               state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: handshake strobes and response valid.
  always_comb begin
    ReqReady0 = accept_s && !grant_sel_s;
    ReqReady1 = accept_s && grant_sel_s;
    RspValid  = (state_r == RESP);
  end

  // Operand drive registers fall back to zero (no-op) on every cycle without an accept,
  // so the ALU only sees live operands during EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r         <= 4'h0;
      shamt_r      <= 5'd0;
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      grant_id_r   <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      op_r         <= grant_sel_s ? ReqOp1    : ReqOp0;
      shamt_r      <= grant_sel_s ? ReqShamt1 : ReqShamt0;
      a_r          <= grant_sel_s ? ReqA1     : ReqA0;
      b_r          <= grant_sel_s ? ReqB1     : ReqB0;
      grant_id_r   <= grant_sel_s;
      last_grant_r <= grant_sel_s;
    end else begin
      op_r         <= 4'h0;
      shamt_r      <= 5'd0;
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      grant_id_r   <= grant_id_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Response capture at the end of EXEC; held through RESP until the next EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data_r <= 32'd0;
      rsp_zero_r <= 1'b0;
      rsp_id_r   <= 1'b0;
    end else if (state_r == EXEC) begin
      rsp_data_r <= DataOut;
      rsp_zero_r <= Zero;
      rsp_id_r   <= grant_id_r;
    end else begin
      rsp_data_r <= rsp_data_r;
      rsp_zero_r <= rsp_zero_r;
      rsp_id_r   <= rsp_id_r;
    end
  end

  assign ALUOp    = op_r;
  assign shamt    = shamt_r;
  assign DataIn1  = a_r;
  assign regData2 = b_r;
  assign ALUSrc   = 1'b0;
  assign jump     = 1'b0;
  assign RspData  = rsp_data_r;
  assign RspZero  = rsp_zero_r;
  assign RspId    = rsp_id_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each backed by a small behavioural ALU.
module tb_alu_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, v0, v1, rsp_ready;
  logic [3:0]  op0, op1;
  logic [31:0] a0, a1, b0, b1;
  logic [4:0]  sh0, sh1;

  logic        r_rdy0, r_rdy1, r_rv, r_rz, r_rid, r_src, r_jmp, r_z;
  logic [31:0] r_rd, r_d1, r_d2, r_do;
  logic [3:0]  r_op;
  logic [4:0]  r_sh;
  logic        f_rdy0, f_rdy1, f_rv, f_rz, f_rid, f_src, f_jmp, f_z;
  logic [31:0] f_rd, f_d1, f_d2, f_do;
  logic [3:0]  f_op;
  logic [4:0]  f_sh;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'h1:    return a + b;
      4'h3:    return a - b;
      4'h5:    return a & b;
      4'h9:    return b << sh;
      default: return 32'd0;
    endcase
  endfunction

  assign r_do = alu_f(r_op, r_d1, r_d2, r_sh);
  assign r_z  = (r_do == 32'd0);
  assign f_do = alu_f(f_op, f_d1, f_d2, f_sh);
  assign f_z  = (f_do == 32'd0);

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .reset(reset), .ReqValid0(v0), .ReqValid1(v1),
    .ReqReady0(r_rdy0), .ReqReady1(r_rdy1), .ReqOp0(op0), .ReqOp1(op1),
    .ReqA0(a0), .ReqA1(a1), .ReqB0(b0), .ReqB1(b1), .ReqShamt0(sh0), .ReqShamt1(sh1),
    .RspValid(r_rv), .RspReady(rsp_ready), .RspData(r_rd), .RspZero(r_rz), .RspId(r_rid),
    .ALUOp(r_op), .shamt(r_sh), .DataIn1(r_d1), .regData2(r_d2), .ALUSrc(r_src),
    .jump(r_jmp), .DataOut(r_do), .Zero(r_z));

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .ReqValid0(v0), .ReqValid1(v1),
    .ReqReady0(f_rdy0), .ReqReady1(f_rdy1), .ReqOp0(op0), .ReqOp1(op1),
    .ReqA0(a0), .ReqA1(a1), .ReqB0(b0), .ReqB1(b1), .ReqShamt0(sh0), .ReqShamt1(sh1),
    .RspValid(f_rv), .RspReady(rsp_ready), .RspData(f_rd), .RspZero(f_rz), .RspId(f_rid),
    .ALUOp(f_op), .shamt(f_sh), .DataIn1(f_d1), .regData2(f_d2), .ALUSrc(f_src),
    .jump(f_jmp), .DataOut(f_do), .Zero(f_z));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
    if (id) begin
      v1 = 1'b1; op1 = op; a1 = a; b1 = b; sh1 = sh;
    end else begin
      v0 = 1'b1; op0 = op; a0 = a; b0 = b; sh0 = sh;
    end
  endtask

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp_d;
    logic        exp_z;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 4'h1, 32'd5,          32'd7,      5'd0, 32'd12,   1'b0};
    vecs[1] = '{1'b1, 4'h3, 32'h1234,       32'h1234,   5'd0, 32'd0,    1'b1};
    vecs[2] = '{1'b0, 4'h5, 32'hF0,         32'h3C,     5'd0, 32'h30,   1'b0};
    vecs[3] = '{1'b1, 4'h9, 32'd0,          32'd1,      5'd4, 32'd16,   1'b0};
    vecs[4] = '{1'b0, 4'h0, 32'h55,         32'h66,     5'd3, 32'd0,    1'b1};
    vecs[5] = '{1'b1, 4'hE, 32'h77,         32'h88,     5'd1, 32'd0,    1'b1};
    vecs[6] = '{1'b0, 4'hF, 32'hFFFFFFFF,   32'h1,      5'd9, 32'd0,    1'b1};
    vecs[7] = '{1'b1, 4'h1, 32'hFFFFFFFF,   32'd1,      5'd0, 32'd0,    1'b1};

    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
    op0 = 4'h0; op1 = 4'h0; a0 = 32'd0; a1 = 32'd0; b0 = 32'd0; b1 = 32'd0;
    sh0 = 5'd0; sh1 = 5'd0;

    // Reset state, including ReqReady suppressed while reset is high.
    repeat (2) @(negedge clk);
    v0 = 1'b1;
    #1;
    chk("rst_rdy0", 32'(r_rdy0), 32'd0);
    chk("rst_rv", 32'(r_rv), 32'd0);
    chk("rst_rd", r_rd, 32'd0);
    chk("rst_rz_rid", {30'd0, r_rz, r_rid}, 32'd0);
    chk("rst_op_sh", {23'd0, r_op, r_sh}, 32'd0);
    chk("rst_d1", r_d1, 32'd0);
    chk("rst_d2", r_d2, 32'd0);
    chk("tied_src_jmp", {30'd0, r_src, r_jmp}, 32'd0);
    v0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Table: single requests, latency, result capture and operand isolation.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      #1;
      chk($sformatf("v%0d_rdy", i), {30'd0, r_rdy1, r_rdy0}, vecs[i].id ? 32'd2 : 32'd1);
      @(posedge clk);
      #1;
      v0 = 1'b0; v1 = 1'b0; a0 = 32'hFFFFFFFF; a1 = 32'hFFFFFFFF;
      @(negedge clk);
      chk($sformatf("v%0d_exec_rv", i), 32'(r_rv), 32'd0);
      chk($sformatf("v%0d_exec_op", i), 32'(r_op), 32'(vecs[i].op));
      chk($sformatf("v%0d_exec_a", i), r_d1, vecs[i].a);
      @(negedge clk);
      chk($sformatf("v%0d_rv", i), 32'(r_rv), 32'd1);
      chk($sformatf("v%0d_data", i), r_rd, vecs[i].exp_d);
      chk($sformatf("v%0d_zero", i), 32'(r_rz), 32'(vecs[i].exp_z));
      chk($sformatf("v%0d_id", i), 32'(r_rid), 32'(vecs[i].id));
      chk($sformatf("v%0d_resp_op", i), 32'(r_op), 32'd0);
    end

    // Contention: both valid continuously, RspReady=1.
    @(negedge clk);
    drive_req(1'b0, 4'h1, 32'd1, 32'd1, 5'd0);
    drive_req(1'b1, 4'h1, 32'd10, 32'd0, 5'd0);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c % 2 == 0) begin
        chk($sformatf("rr_c%0d_rdy", c), {30'd0, r_rdy1, r_rdy0},
            ((c / 2) % 2 == 0) ? 32'd1 : 32'd2);
        chk($sformatf("fp_c%0d_rdy", c), {30'd0, f_rdy1, f_rdy0}, 32'd1);
      end else begin
        chk($sformatf("rr_c%0d_rdy", c), {30'd0, r_rdy1, r_rdy0}, 32'd0);
        chk($sformatf("fp_c%0d_rdy", c), {30'd0, f_rdy1, f_rdy0}, 32'd0);
      end
      if (c % 2 == 0 && c >= 2) begin
        chk($sformatf("rr_c%0d_id", c), 32'(r_rid), 32'(((c / 2) - 1) % 2));
        chk($sformatf("rr_c%0d_data", c), r_rd, (((c / 2) - 1) % 2 == 0) ? 32'd2 : 32'd10);
        chk($sformatf("fp_c%0d_id", c), 32'(f_rid), 32'd0);
        chk($sformatf("fp_c%0d_rv", c), 32'(f_rv), 32'd1);
      end
      @(negedge clk);
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure: result held, no grants, pending Req1 accepted on the release cycle.
    rsp_ready = 1'b0;
    drive_req(1'b0, 4'h9, 32'd0, 32'd1, 5'd4);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive_req(1'b1, 4'h1, 32'd3, 32'd4, 5'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_rdy", k), {30'd0, r_rdy1, r_rdy0}, 32'd0);
      chk($sformatf("bp%0d_rv", k), 32'(r_rv), 32'd1);
      chk($sformatf("bp%0d_data", k), r_rd, 32'd16);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_rdy1", 32'(r_rdy1), 32'd1);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(negedge clk);
    chk("bp_exec_rv", 32'(r_rv), 32'd0);
    @(negedge clk);
    chk("bp2_rv", 32'(r_rv), 32'd1);
    chk("bp2_data", r_rd, 32'd7);
    chk("bp2_id", 32'(r_rid), 32'd1);
    @(negedge clk);

    // Reset during EXEC discards the operation and restores requester-0 priority.
    drive_req(1'b0, 4'h1, 32'd1, 32'd2, 5'd0);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive_req(1'b0, 4'h1, 32'd4, 32'd5, 5'd0);
    drive_req(1'b1, 4'h1, 32'd20, 32'd0, 5'd0);
    #1;
    chk("mid_rst_rv", 32'(r_rv), 32'd0);
    chk("mid_rst_rdy", {30'd0, r_rdy1, r_rdy0}, 32'd0);
    chk("mid_rst_op", 32'(r_op), 32'd0);
    chk("mid_rst_d1", r_d1, 32'd0);
    chk("mid_rst_rd", r_rd, 32'd0);
    @(negedge clk);
    chk("mid_rst_rv2", 32'(r_rv), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_rdy", {30'd0, r_rdy1, r_rdy0}, 32'd1);
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk("post_rst_exec_rv", 32'(r_rv), 32'd0);
    @(negedge clk);
    chk("post_rst_rv", 32'(r_rv), 32'd1);
    chk("post_rst_data", r_rd, 32'd9);
    chk("post_rst_id", 32'(r_rid), 32'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU between two requesters: the main datapath (requester 0) and the branch/address unit (requester 1). Each requester uses a valid/ready handshake. The block registers the granted operands and drives the ALU's ALUOp, shamt, DataIn1 and regData2 inputs. It captures DataOut/Zero one cycle later and returns them on a shared response channel tagged with the requester ID. Arbitration is round-robin, with an optional fixed-priority mode.

## Interface
- RR_EN, default 1: 1 selects round-robin; 0 gives requester 0 fixed priority.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ReqValid0 / ReqValid1  in  1  request present.
- ReqReady0 / ReqReady1  out  1  request accepted this cycle (combinational).
- ReqOp0 / ReqOp1  in  4  ALU opcode, same encoding as ALUOp.
- ReqA0 / ReqA1  in  32  first operand.
- ReqB0 / ReqB1  in  32  second operand.
- ReqShamt0 / ReqShamt1  in  5  shift amount.
- RspValid  out  1  result available.
- RspReady  in  1  consumer takes the result.
- RspData  out  32  captured DataOut.
- RspZero  out  1  captured Zero.
- RspId  out  1  requester that owns the result.
- ALUOp  out  4  to ALU.
- shamt  out  5  to ALU.
- DataIn1  out  32  to ALU.
- regData2  out  32  to ALU.
- ALUSrc  out  1  to ALU; tied to 0.
- jump  out  1  to ALU; tied to 0.
- DataOut  in  32  from ALU.
- Zero  in  1  from ALU.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - EXEC: operands are registered and drive the ALU.
  - RESP: RspValid=1, waiting for RspReady.
- Accept window: open when state==IDLE, or state==RESP && RspReady==1.
- Grant within the accept window:
  - Only one ReqValid high: that requester is granted.
  - Both high, RR_EN=1: the requester other than LastGrant is granted.
  - Both high, RR_EN=0: requester 0 is granted.
  - Only the granted requester sees ReqReady=1. The other ReqReady is 0 and its ReqValid is ignored.
- On accept:
  - Op, A, B and Shamt are registered into the ALU drive registers.
  - GrantId is registered and LastGrant is updated.
  - Next state is EXEC.
- EXEC:
  - The ALU drive registers are presented to the ALU.
  - DataOut and Zero are captured into RspData/RspZero at the end of the cycle, and RspId is set to GrantId.
  - Next state is RESP. EXEC always lasts exactly 1 cycle.
- RESP:
  - RspValid=1, and RspData/RspZero/RspId are held stable while RspReady=0.
  - On RspReady=1 with no accept, next state is IDLE.
  - On RspReady=1 with a simultaneous accept, next state is EXEC.
- In IDLE, and in RESP when no new accept occurs, ALUOp is driven to 4'h0 (no-op) and DataIn1/regData2/shamt to 0. The ALU output is don't-care outside EXEC.
- Opcodes 4'h0, 4'hE and 4'hF are accepted and executed normally; the result is whatever the ALU returns (0 with Zero=1).
- No operand width conversion: 32-bit passthrough, 5-bit shamt passthrough.

## Timing
- Reset values:
  - State IDLE, LastGrant=1 (so requester 0 wins the first contention).
  - RspValid=0, RspData=0, RspZero=0, RspId=0.
  - ALUOp=0, shamt=0, DataIn1=0, regData2=0.
  - ReqReady0/1=0 while reset is high.
- Latency: accept in cycle N, EXEC in cycle N+1, RspValid=1 in cycle N+2.
- Peak throughput: one operation per 2 cycles, achieved by back-to-back accepts in RESP with RspReady=1.
- Reset asserted mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is issued, and RspValid drops asynchronously.
- A requester may change ReqA/ReqB after its ReqReady cycle; the block uses only the registered copies.
- ReqValid deasserted without ReqReady: no side effects.
- LastGrant changes only on accept. A single-requester grant also updates it.

## Test plan
- Single op: Req0 ALUOp=1, A=5, B=7, Shamt=0 -> ReqReady0 in cycle N; RspValid in cycle N+2 with RspData=12, RspZero=0, RspId=0.
- Zero flag: Req1 ALUOp=3, A=B=32'h1234 -> RspData=0, RspZero=1, RspId=1.
- Contention, RR_EN=1: both requesters valid continuously with RspReady=1 -> grants alternate 0,1,0,1, one accept every 2 cycles, RspId alternating. With RR_EN=0 -> requester 0 granted every time and requester 1 never granted.
- Backpressure: RspReady=0 for 5 cycles after RspValid with ALUOp=9, B=1, Shamt=4 -> RspData=16 held stable, ReqReady0/1=0 throughout; on RspReady=1 a pending Req1 is accepted in that same cycle.
- Reset mid-operation: assert reset during EXEC -> RspValid never asserts, outputs return to their reset values, and the first post-reset contention grants requester 0.
- Operand isolation: change ReqA0 to 32'hFFFFFFFF the cycle after accept with ALUOp=5, A=32'hF0, B=32'h3C -> RspData=32'h30.
